// File: rtl/trace_line_reader.sv
// Purpose: unpacks one trace line (chars stored downward from the top byte, cursor in bits [15:0]) into a byte stream.
// Latency: the first character is valid the cycle after the line is accepted; then one byte per accepted transfer.
// Backpressure: out_rdy low holds out_msg/out_last stable; in_rdy stays low until the line, and its newline if enabled, drains.
module trace_line_reader #(
    parameter int p_nchars       = 512,
    parameter bit p_emit_newline = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [p_nchars*8-1:0]   in_msg,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [7:0]              out_msg,
    output logic                    out_last,
    output logic [31:0]             line_count
);

    localparam int              IW        = $clog2(p_nchars);
    localparam logic [IW-1:0]   TOP_IDX   = IW'(p_nchars - 1);
    localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
    localparam logic [15:0]     EMPTY_CUR = 16'(p_nchars - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        EOL
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [p_nchars*8-1:0]  line_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          stop_q;

    logic [15:0]            cur_raw;
    logic [15:0]            cur_clamp;
    logic                   line_empty;
    logic                   at_stop;
    logic [7:0]             cur_byte;
    logic                   load;
    logic                   dec;
    logic                   cnt_inc;

    // Bytes 0/1 carry the cursor, so a zero cursor still starts the text at byte 2.
    assign cur_raw    = in_msg[15:0];
    assign cur_clamp  = (cur_raw == 16'd0) ? 16'd1 : cur_raw;
    assign line_empty = (cur_clamp >= EMPTY_CUR);
    assign at_stop    = (idx_q == stop_q + IDX_ONE);
    assign cur_byte   = line_q[{idx_q, 3'b000} +: 8];

    // Next-state and output decode; outputs depend only on registered state, never on out_rdy.
    always_comb begin
        state_d  = state_q;
        in_rdy   = 1'b0;
        out_val  = 1'b0;
        out_msg  = 8'h00;
        out_last = 1'b0;
        load     = 1'b0;
        dec      = 1'b0;
        cnt_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = !reset;
                if (in_val && !reset) begin
                    load = 1'b1;
                    if (!line_empty) begin
                        state_d = STREAM;
                    end else if (p_emit_newline) begin
                        state_d = EOL;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            STREAM: begin
                out_val  = 1'b1;
                out_msg  = cur_byte;
                out_last = !p_emit_newline && at_stop;
                if (out_rdy) begin
                    if (at_stop) begin
                        if (p_emit_newline) begin
                            state_d = EOL;
                        end else begin
                            state_d = IDLE;
                            cnt_inc = 1'b1;
                        end
                    end else begin
                        dec = 1'b1;
                    end
                end
            end
            EOL: begin
                out_val  = 1'b1;
                out_msg  = 8'h0A;
                out_last = 1'b1;
                if (out_rdy) begin
                    state_d = IDLE;
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, byte index, stop point and completed-line counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            stop_q     <= '0;
            line_count <= 32'd0;
        end else begin
            state_q <= state_d;
            if (load) begin
                idx_q  <= TOP_IDX;
                stop_q <= cur_clamp[IW-1:0];
            end else if (dec) begin
                idx_q <= idx_q - IDX_ONE;
            end
            if (cnt_inc) begin
                line_count <= line_count + 32'd1;
            end
        end
    end

    // Line buffer is pure datapath: captured only on acceptance, ignored otherwise.
    always_ff @(posedge clk) begin
        if (load) begin
            line_q <= in_msg;
        end
    end

endmodule
